// File: rtl/traffic_monitor_pkg.sv
// Shared definitions for the traffic light monitor: light codes, error codes,
// FSM state type and a one-hot helper.
package traffic_monitor_pkg;

   // Car light codes (one-hot)
   localparam logic [3:0] CAR_GREEN  = 4'b0001;
   localparam logic [3:0] CAR_LEFT   = 4'b0010;
   localparam logic [3:0] CAR_YELLOW = 4'b0100;
   localparam logic [3:0] CAR_RED    = 4'b1000;

   // Walker light codes
   localparam logic [1:0] WALK_OFF   = 2'b00;
   localparam logic [1:0] WALK_GREEN = 2'b01;
   localparam logic [1:0] WALK_RED   = 2'b10;
   localparam logic [1:0] WALK_BAD   = 2'b11;

   // Error codes reported on o_err_code
   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_BAD_CAR   = 3'd1;
   localparam logic [2:0] ERR_BAD_TRANS = 3'd2;
   localparam logic [2:0] ERR_CONFLICT  = 3'd3;
   localparam logic [2:0] ERR_STUCK     = 3'd4;
   localparam logic [2:0] ERR_BAD_WALK  = 3'd5;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_TRACK = 1'b1
   } mon_state_t;

   // True when exactly one bit of the car code is set
   function automatic logic is_onehot4(input logic [3:0] c);
      return (c != 4'd0) && ((c & (c - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/traffic_monitor_if.sv
// Sample/report bundle between the light sampler (master) and the monitor (slave).
interface traffic_monitor_if #(
   parameter int CNT_W = 7
);
   logic             i_en;
   logic [3:0]       i_car;
   logic [1:0]       i_walk;
   logic             o_phase_valid;
   logic [3:0]       o_phase_code;
   logic [CNT_W-1:0] o_phase_len;
   logic             o_err_valid;
   logic [2:0]       o_err_code;
   logic             o_err_sticky;
   logic [7:0]       o_cycles;

   modport master (
      output i_en, i_car, i_walk,
      input  o_phase_valid, o_phase_code, o_phase_len,
      input  o_err_valid, o_err_code, o_err_sticky, o_cycles
   );

   modport slave (
      input  i_en, i_car, i_walk,
      output o_phase_valid, o_phase_code, o_phase_len,
      output o_err_valid, o_err_code, o_err_sticky, o_cycles
   );
endinterface

// File: rtl/traffic_seq_check.sv
// Combinational checks on a car code pair: is the new code one-hot, is it
// unchanged, and is the change one of the permitted light sequences.
module traffic_seq_check
   import traffic_monitor_pkg::*;
(
   input  logic [3:0] prev_code,
   input  logic [3:0] cur_code,
   output logic       cur_onehot,
   output logic       same_code,
   output logic       trans_legal
);

   // Legal sequence table; only meaningful when the code actually changes
   always_comb begin
      cur_onehot  = is_onehot4(cur_code);
      same_code   = (prev_code == cur_code);
      trans_legal = 1'b0;
      case ({prev_code, cur_code})
         {CAR_GREEN,  CAR_YELLOW}: trans_legal = 1'b1;
         {CAR_YELLOW, CAR_LEFT}:   trans_legal = 1'b1;
         {CAR_YELLOW, CAR_RED}:    trans_legal = 1'b1;
         {CAR_LEFT,   CAR_YELLOW}: trans_legal = 1'b1;
         {CAR_RED,    CAR_GREEN}:  trans_legal = 1'b1;
         default:                  trans_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/traffic_monitor.sv
// Traffic light monitor: tracks car phases, reports each finished phase with
// its length, and flags illegal codes, sequences, walker conflicts and stuck
// phases. All outputs are registered one cycle after the offending sample.
module traffic_monitor
   import traffic_monitor_pkg::*;
#(
   parameter int MAX_HOLD = 40,
   parameter int CNT_W    = 7
) (
   input logic              clk,
   input logic              reset_n,
   traffic_monitor_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [31:0]      STUCK_AT = 32'(MAX_HOLD + 1);

   mon_state_t       state_q, state_d;
   logic [3:0]       prev_code_q, prev_code_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stuck_done_q, stuck_done_d;
   logic             phase_valid_q, phase_valid_d;
   logic [3:0]       phase_code_q, phase_code_d;
   logic [CNT_W-1:0] phase_len_q, phase_len_d;
   logic             err_valid_q, err_valid_d;
   logic [2:0]       err_code_q, err_code_d;
   logic             err_sticky_q, err_sticky_d;
   logic [7:0]       cycles_q, cycles_d;

   logic             cur_onehot, same_code, trans_legal;
   logic [CNT_W-1:0] cnt_inc;
   logic             e_car, e_walk, e_trans, e_conf, e_stuck;

   traffic_seq_check u_seq_check (
      .prev_code   (prev_code_q),
      .cur_code    (bus.i_car),
      .cur_onehot  (cur_onehot),
      .same_code   (same_code),
      .trans_legal (trans_legal)
   );

   // Phase length counter saturates instead of wrapping
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   // Next-state, phase tracking and error detection for one enabled sample
   always_comb begin
      state_d       = state_q;
      prev_code_d   = prev_code_q;
      cnt_d         = cnt_q;
      stuck_done_d  = stuck_done_q;
      phase_valid_d = 1'b0;
      phase_code_d  = phase_code_q;
      phase_len_d   = phase_len_q;
      err_valid_d   = 1'b0;
      err_code_d    = err_code_q;
      err_sticky_d  = err_sticky_q;
      cycles_d      = cycles_q;
      e_car         = 1'b0;
      e_walk        = 1'b0;
      e_trans       = 1'b0;
      e_conf        = 1'b0;
      e_stuck       = 1'b0;

      if (bus.i_en) begin
         e_walk = (bus.i_walk == WALK_BAD);
         e_conf = (bus.i_walk == WALK_GREEN) && (bus.i_car != CAR_RED);

         case (state_q)
            ST_IDLE: begin
               if (cur_onehot) begin
                  prev_code_d  = bus.i_car;
                  cnt_d        = CNT_ONE;
                  stuck_done_d = 1'b0;
                  state_d      = ST_TRACK;
               end else begin
                  e_car = 1'b1;
               end
            end
            ST_TRACK: begin
               if (!cur_onehot) begin
                  // Partial phase is abandoned; code and counter keep their values
                  e_car   = 1'b1;
                  state_d = ST_IDLE;
               end else if (same_code) begin
                  cnt_d = cnt_inc;
                  if ((32'(cnt_inc) == STUCK_AT) && !stuck_done_q) begin
                     e_stuck      = 1'b1;
                     stuck_done_d = 1'b1;
                  end
               end else begin
                  phase_valid_d = 1'b1;
                  phase_code_d  = prev_code_q;
                  phase_len_d   = cnt_q;
                  prev_code_d   = bus.i_car;
                  cnt_d         = CNT_ONE;
                  stuck_done_d  = 1'b0;
                  e_trans       = !trans_legal;
                  if ((prev_code_q == CAR_RED) && (bus.i_car == CAR_GREEN)) begin
                     cycles_d = cycles_q + 8'd1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase

         // One pulse per sample; code chosen by fixed priority
         if (e_car || e_walk || e_trans || e_conf || e_stuck) begin
            err_valid_d  = 1'b1;
            err_sticky_d = 1'b1;
            if (e_car)        err_code_d = ERR_BAD_CAR;
            else if (e_walk)  err_code_d = ERR_BAD_WALK;
            else if (e_trans) err_code_d = ERR_BAD_TRANS;
            else if (e_conf)  err_code_d = ERR_CONFLICT;
            else              err_code_d = ERR_STUCK;
         end
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         prev_code_q   <= 4'd0;
         cnt_q         <= '0;
         stuck_done_q  <= 1'b0;
         phase_valid_q <= 1'b0;
         phase_code_q  <= 4'd0;
         phase_len_q   <= '0;
         err_valid_q   <= 1'b0;
         err_code_q    <= ERR_NONE;
         err_sticky_q  <= 1'b0;
         cycles_q      <= 8'd0;
      end else begin
         state_q       <= state_d;
         prev_code_q   <= prev_code_d;
         cnt_q         <= cnt_d;
         stuck_done_q  <= stuck_done_d;
         phase_valid_q <= phase_valid_d;
         phase_code_q  <= phase_code_d;
         phase_len_q   <= phase_len_d;
         err_valid_q   <= err_valid_d;
         err_code_q    <= err_code_d;
         err_sticky_q  <= err_sticky_d;
         cycles_q      <= cycles_d;
      end
   end

   assign bus.o_phase_valid = phase_valid_q;
   assign bus.o_phase_code  = phase_code_q;
   assign bus.o_phase_len   = phase_len_q;
   assign bus.o_err_valid   = err_valid_q;
   assign bus.o_err_code    = err_code_q;
   assign bus.o_err_sticky  = err_sticky_q;
   assign bus.o_cycles      = cycles_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: a table of single-sample vectors with
// hand-computed expectations, plus sequences for long phases, stuck
// detection with enable gaps, and reset in the middle of a phase.
module tb_traffic_monitor;
   import traffic_monitor_pkg::*;

   localparam int CNT_W = 7;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   traffic_monitor_if #(.CNT_W(CNT_W)) bus ();

   traffic_monitor #(.MAX_HOLD(40), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit             rst_n;
      bit             en;
      logic [3:0]     car;
      logic [1:0]     walk;
      bit             pv;
      logic [3:0]     pc;
      logic [CNT_W-1:0] pl;
      bit             ev;
      logic [2:0]     ec;
      bit             es;
      logic [7:0]     cyc;
   } vec_t;

   vec_t tbl [16];

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] ph_code [6];
   int         ph_len  [6];

   task automatic apply(input bit rst_n, input bit en, input logic [3:0] car,
                        input logic [1:0] walk);
      reset_n    = rst_n;
      bus.i_en   = en;
      bus.i_car  = car;
      bus.i_walk = walk;
      @(posedge clk);
      #1;
      n_vec++;
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input bit pv, input logic [3:0] pc,
                          input logic [CNT_W-1:0] pl, input bit ev, input logic [2:0] ec,
                          input bit es, input logic [7:0] cyc);
      cmp({nm, ".phase_valid"}, 32'(bus.o_phase_valid), 32'(pv));
      cmp({nm, ".phase_code"},  32'(bus.o_phase_code),  32'(pc));
      cmp({nm, ".phase_len"},   32'(bus.o_phase_len),   32'(pl));
      cmp({nm, ".err_valid"},   32'(bus.o_err_valid),   32'(ev));
      cmp({nm, ".err_code"},    32'(bus.o_err_code),    32'(ec));
      cmp({nm, ".err_sticky"},  32'(bus.o_err_sticky),  32'(es));
      cmp({nm, ".cycles"},      32'(bus.o_cycles),      32'(cyc));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ev_cnt;
      int k;

      bus.i_en   = 1'b0;
      bus.i_car  = 4'd0;
      bus.i_walk = WALK_OFF;

      //            rst en car         walk        pv pc          pl  ev ec es cyc
      tbl[0]  = '{0, 1, CAR_GREEN,  WALK_RED,   0, 4'd0,       0,  0, 0, 0, 0};
      tbl[1]  = '{1, 1, CAR_GREEN,  WALK_RED,   0, 4'd0,       0,  0, 0, 0, 0};
      tbl[2]  = '{1, 1, CAR_GREEN,  WALK_GREEN, 0, 4'd0,       0,  1, 3, 1, 0};
      tbl[3]  = '{1, 1, CAR_GREEN,  WALK_RED,   0, 4'd0,       0,  0, 3, 1, 0};
      tbl[4]  = '{1, 0, CAR_RED,    WALK_BAD,   0, 4'd0,       0,  0, 3, 1, 0};
      tbl[5]  = '{1, 1, CAR_RED,    WALK_RED,   1, CAR_GREEN,  3,  1, 2, 1, 0};
      tbl[6]  = '{1, 1, CAR_RED,    WALK_GREEN, 0, CAR_GREEN,  3,  0, 2, 1, 0};
      tbl[7]  = '{1, 1, CAR_GREEN,  WALK_RED,   1, CAR_RED,    2,  0, 2, 1, 1};
      tbl[8]  = '{1, 1, 4'b0011,    WALK_BAD,   0, CAR_RED,    2,  1, 1, 1, 1};
      tbl[9]  = '{1, 1, CAR_YELLOW, WALK_RED,   0, CAR_RED,    2,  0, 1, 1, 1};
      tbl[10] = '{1, 1, CAR_LEFT,   WALK_RED,   1, CAR_YELLOW, 1,  0, 1, 1, 1};
      tbl[11] = '{1, 1, CAR_LEFT,   WALK_BAD,   0, CAR_YELLOW, 1,  1, 5, 1, 1};
      tbl[12] = '{1, 1, CAR_YELLOW, WALK_GREEN, 1, CAR_LEFT,   2,  1, 3, 1, 1};
      tbl[13] = '{1, 1, CAR_GREEN,  WALK_OFF,   1, CAR_YELLOW, 1,  1, 2, 1, 1};
      tbl[14] = '{0, 1, CAR_LEFT,   WALK_RED,   0, 4'd0,       0,  0, 0, 0, 0};
      tbl[15] = '{1, 1, 4'b0000,    WALK_OFF,   0, 4'd0,       0,  1, 1, 1, 0};

      for (int i = 0; i < 16; i++) begin
         apply(tbl[i].rst_n, tbl[i].en, tbl[i].car, tbl[i].walk);
         chk_out($sformatf("vec%0d", i), tbl[i].pv, tbl[i].pc, tbl[i].pl,
                 tbl[i].ev, tbl[i].ec, tbl[i].es, tbl[i].cyc);
      end

      // Nominal cycle: GREEN 20, YELLOW 2, LEFT 10, YELLOW 2, RED 34, GREEN
      ph_code = '{CAR_GREEN, CAR_YELLOW, CAR_LEFT, CAR_YELLOW, CAR_RED, CAR_GREEN};
      ph_len  = '{20, 2, 10, 2, 34, 1};
      apply(0, 1, CAR_GREEN, WALK_RED);
      for (int p = 0; p < 6; p++) begin
         for (int s = 0; s < ph_len[p]; s++) begin
            apply(1, 1, ph_code[p], WALK_RED);
            if (p > 0 && s == 0) begin
               cmp($sformatf("nom.p%0d.pv", p), 32'(bus.o_phase_valid), 32'd1);
               cmp($sformatf("nom.p%0d.pc", p), 32'(bus.o_phase_code), 32'(ph_code[p-1]));
               cmp($sformatf("nom.p%0d.pl", p), 32'(bus.o_phase_len), 32'(ph_len[p-1]));
            end else begin
               cmp($sformatf("nom.p%0d.s%0d.pv", p, s), 32'(bus.o_phase_valid), 32'd0);
            end
            cmp($sformatf("nom.p%0d.s%0d.ev", p, s), 32'(bus.o_err_valid), 32'd0);
         end
      end
      cmp("nom.cycles", 32'(bus.o_cycles), 32'd1);
      cmp("nom.sticky", 32'(bus.o_err_sticky), 32'd0);

      // Stuck RED: 51 enabled samples with disabled gaps; single error at sample 41
      apply(0, 1, CAR_RED, WALK_RED);
      ev_cnt = 0;
      for (k = 1; k <= 51; k++) begin
         if (k % 5 == 0) begin
            apply(1, 0, CAR_GREEN, WALK_BAD);
            cmp($sformatf("stuck.gap%0d.ev", k), 32'(bus.o_err_valid), 32'd0);
            cmp($sformatf("stuck.gap%0d.pv", k), 32'(bus.o_phase_valid), 32'd0);
         end
         apply(1, 1, CAR_RED, WALK_GREEN);
         if (bus.o_err_valid) ev_cnt++;
         if (k == 41) begin
            cmp("stuck.k41.ev", 32'(bus.o_err_valid), 32'd1);
            cmp("stuck.k41.ec", 32'(bus.o_err_code), 32'(ERR_STUCK));
         end else begin
            cmp($sformatf("stuck.k%0d.ev", k), 32'(bus.o_err_valid), 32'd0);
         end
      end
      cmp("stuck.pulses", 32'(ev_cnt), 32'd1);
      apply(1, 1, CAR_GREEN, WALK_RED);
      chk_out("stuck.end", 1, CAR_RED, 7'd51, 0, ERR_STUCK, 1, 8'd1);

      // Reset in the middle of a LEFT phase after an error
      apply(0, 1, CAR_GREEN, WALK_RED);
      for (int s = 0; s < 3; s++) apply(1, 1, CAR_GREEN, WALK_RED);
      apply(1, 1, CAR_YELLOW, WALK_RED);
      for (int s = 0; s < 3; s++) apply(1, 1, CAR_LEFT, WALK_RED);
      chk_out("rst.pre", 0, CAR_YELLOW, 7'd1, 0, 0, 0, 8'd0);
      apply(1, 1, CAR_LEFT, WALK_BAD);
      chk_out("rst.err", 0, CAR_YELLOW, 7'd1, 1, ERR_BAD_WALK, 1, 8'd0);
      apply(0, 1, CAR_LEFT, WALK_RED);
      chk_out("rst.asserted", 0, 4'd0, 7'd0, 0, 0, 0, 8'd0);
      apply(1, 1, CAR_LEFT, WALK_RED);
      chk_out("rst.first", 0, 4'd0, 7'd0, 0, 0, 0, 8'd0);
      apply(1, 1, CAR_YELLOW, WALK_RED);
      chk_out("rst.next", 1, CAR_LEFT, 7'd1, 0, 0, 0, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/traffic_monitor.md
TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 Parameter MAX_HOLD, default 40: maximum legal cycles a car phase may persist before a stuck error.
REQ-002 Parameter CNT_W, default 7: width of phase-length counter.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 i_en  input  1  sample enable; when low, all state and outputs hold and pulses are 0.
REQ-006 i_car  input  4  car light code (GREEN 0001, LEFT 0010, YELLOW 0100, RED 1000).
REQ-007 i_walk  input  2  walker light code (RED 10, GREEN 01, OFF 00; 11 illegal).
REQ-008 o_phase_valid  output  1  one-cycle pulse: a car phase ended.
REQ-009 o_phase_code  output  4  code of the phase that ended.
REQ-010 o_phase_len  output  CNT_W  sampled cycles that phase lasted.
REQ-011 o_err_valid  output  1  one-cycle pulse: error detected this sample.
REQ-012 o_err_code  output  3  error code, held until next error or reset.
REQ-013 o_err_sticky  output  1  set on any error, cleared only by reset.
REQ-014 o_cycles  output  8  count of completed RED->GREEN transitions, wraps 255->0.

Function
REQ-015 FSM states: IDLE (no valid previous sample), TRACK (previous car code known); all checks below apply only on cycles with i_en=1.
REQ-016 IDLE: on a sample with legal one-hot i_car, store it as previous code, phase counter=1, go TRACK; illegal i_car raises error 1 and stays IDLE.
REQ-017 Legal car transitions: GREEN->YELLOW, YELLOW->LEFT, YELLOW->RED, LEFT->YELLOW, RED->GREEN; same code = no transition.
REQ-018 TRACK, same code: phase counter increments, saturating at all-ones.
REQ-019 TRACK, code change: o_phase_valid=1 with o_phase_code=previous code and o_phase_len=counter value, registered (1-cycle latency after the changing sample); counter reloads to 1; previous code updates to new code.
REQ-020 Illegal transition (legal one-hot, not in REQ-017) raises error 2, still reports phase and updates previous code.
REQ-021 Non-one-hot i_car in TRACK raises error 1; previous code and counter hold; FSM returns to IDLE.
REQ-022 i_walk=01 while i_car != RED raises error 3 (conflict).
REQ-023 Counter reaching MAX_HOLD+1 raises error 4 once per phase (not repeated until next change).
REQ-024 i_walk=11 raises error 5.
REQ-025 Simultaneous errors: one o_err_valid pulse; o_err_code by priority 1 > 5 > 2 > 3 > 4.
REQ-026 RED->GREEN transition increments o_cycles.
REQ-027 All outputs registered; error pulse same latency as phase pulse (1 cycle after offending sample).

Reset
REQ-028 reset_n=0 at clk edge: FSM IDLE, counter 0, previous code 0, o_phase_valid 0, o_phase_code 0, o_phase_len 0, o_err_valid 0, o_err_code 0, o_err_sticky 0, o_cycles 0.
REQ-029 Reset mid-phase discards the partial phase; no phase pulse is emitted for it.

Structure
REQ-030 Shared package holds car/walker code constants and the 3-bit error code constants (0 none, 1 bad car, 2 bad transition, 3 conflict, 4 stuck, 5 bad walker).
REQ-031 One sub-module, traffic_seq_check: combinational legal-transition and one-hot check, inputs previous/current code, outputs legal flags.

Verification
REQ-032 Nominal: GREEN 20, YELLOW 2, LEFT 10, YELLOW 2, RED 34, GREEN -> phase pulses with lengths 20,2,10,2,34; o_cycles=1; no errors.
REQ-033 Conflict: i_car=GREEN, i_walk=01 one sample -> o_err_valid 1 cycle later, o_err_code=3, sticky=1.
REQ-034 Illegal transition GREEN->RED -> err code 2 and phase pulse code 0001.
REQ-035 Simultaneous i_car=0011, i_walk=11 -> single pulse, code 1; FSM to IDLE.
REQ-036 Stuck: RED held 41 samples with MAX_HOLD=40 -> exactly one err code 4; i_en=0 gaps do not advance counter.
REQ-037 Reset asserted mid-LEFT phase -> all outputs 0, no phase pulse; next legal sample enters TRACK with counter 1.
